// File: rtl/ham_74_secded_decoder_pkg.sv
// rtl/ham_74_secded_decoder_pkg.sv - shared widths, error classes and data extraction for the SEC-DED decoder
package ham_74_secded_decoder_pkg;

  localparam int CODE_W = 8;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;
  localparam int CNT_W  = 16;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SEC  = 2'b01;
  localparam logic [1:0] ERR_DED  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Data lives at Hamming positions 3, 5, 6, 7 (bit index = position - 1).
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/ham_74_syndrome.sv
// rtl/ham_74_syndrome.sv - combinational Hamming(7,4) syndrome and overall parity of an 8-bit codeword
module ham_74_syndrome
  import ham_74_secded_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              par_o
);

  logic s1;
  logic s2;
  logic s4;

  assign s1 = code_i[0] ^ code_i[2] ^ code_i[4] ^ code_i[6];
  assign s2 = code_i[1] ^ code_i[2] ^ code_i[5] ^ code_i[6];
  assign s4 = code_i[3] ^ code_i[4] ^ code_i[5] ^ code_i[6];

  assign syn_o = {s4, s2, s1};
  assign par_o = ^code_i;

endmodule

// File: rtl/ham_74_secded_decoder.sv
// rtl/ham_74_secded_decoder.sv - two-stage elastic SEC-DED (8,4) decoder with saturating error statistics
module ham_74_secded_decoder
  import ham_74_secded_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic [SYN_W-1:0]  out_syn,
  input  logic              clr_stat,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              ded_irq
);

  logic              adv2;
  logic              v1_q, v1_d;
  logic [CODE_W-1:0] code1_q, code1_d;
  logic [SYN_W-1:0]  syn1_q, syn1_d, syn_calc;
  logic              par1_q, par1_d, par_calc;

  logic              v2_q, v2_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        err_q, err_d;
  logic [SYN_W-1:0]  syn_q, syn_d;

  logic [CODE_W-1:0] flip_mask;
  logic [1:0]        err_class;

  logic              xfer, xfer_sec, xfer_ded;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  logic              ded_irq_q, ded_irq_d;

  ham_74_syndrome u_syndrome (
    .code_i (in_code),
    .syn_o  (syn_calc),
    .par_o  (par_calc)
  );

  // Ready depends only on occupancy and out_ready, never on in_valid.
  assign adv2     = !v2_q || out_ready;
  assign in_ready = !v1_q || adv2;

  always_comb begin
    v1_d    = v1_q;
    code1_d = code1_q;
    syn1_d  = syn1_q;
    par1_d  = par1_q;
    if (in_ready) begin
      v1_d = in_valid;
      if (in_valid) begin
        code1_d = in_code;
        syn1_d  = syn_calc;
        par1_d  = par_calc;
      end
    end
  end

  // A non-zero syndrome only points at a flipped bit when overall parity is odd.
  always_comb begin
    flip_mask = '0;
    if (par1_q && (syn1_q != '0)) begin
      flip_mask[syn1_q - 3'd1] = 1'b1;
    end
    if ((syn1_q == '0) && !par1_q) begin
      err_class = ERR_NONE;
    end else if (par1_q) begin
      err_class = ERR_SEC;
    end else begin
      err_class = ERR_DED;
    end
  end

  always_comb begin
    v2_d   = v2_q;
    data_d = data_q;
    err_d  = err_q;
    syn_d  = syn_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data_d = extract_data(code1_q ^ flip_mask);
        err_d  = err_class;
        syn_d  = syn1_q;
      end
    end
  end

  assign xfer     = v2_q && out_ready;
  assign xfer_sec = xfer && (err_q == ERR_SEC);
  assign xfer_ded = xfer && (err_q == ERR_DED);

  // A clear that coincides with a counted transfer keeps that transfer.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    ded_irq_d = ded_irq_q | xfer_ded;
    if (clr_stat) begin
      sec_cnt_d = xfer_sec ? CNT_W'(1) : '0;
      ded_cnt_d = xfer_ded ? CNT_W'(1) : '0;
      ded_irq_d = xfer_ded;
    end else begin
      if (xfer_sec && (sec_cnt_q != CNT_MAX)) sec_cnt_d = sec_cnt_q + 1'b1;
      if (xfer_ded && (ded_cnt_q != CNT_MAX)) ded_cnt_d = ded_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      code1_q   <= '0;
      syn1_q    <= '0;
      par1_q    <= 1'b0;
      v2_q      <= 1'b0;
      data_q    <= '0;
      err_q     <= ERR_NONE;
      syn_q     <= '0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
      ded_irq_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      code1_q   <= code1_d;
      syn1_q    <= syn1_d;
      par1_q    <= par1_d;
      v2_q      <= v2_d;
      data_q    <= data_d;
      err_q     <= err_d;
      syn_q     <= syn_d;
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
      ded_irq_q <= ded_irq_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_syn   = syn_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;
  assign ded_irq   = ded_irq_q;

endmodule

// File: tb/tb_ham_74_secded_decoder.sv
// tb/tb_ham_74_secded_decoder.sv - directed and randomized self-checking bench for the SEC-DED decoder
module tb_ham_74_secded_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_err;
  logic [2:0]  out_syn;
  logic        clr_stat;
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;
  logic        ded_irq;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  int         msec = 0;
  int         mded = 0;
  logic       mirq = 1'b0;
  logic       stall_prev = 1'b0;

  ham_74_secded_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_syn   (out_syn),
    .clr_stat  (clr_stat),
    .sec_cnt   (sec_cnt),
    .ded_cnt   (ded_cnt),
    .ded_irq   (ded_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: syndrome is the XOR of the positions of all set bits.
  function automatic logic [8:0] ref_decode(input logic [7:0] c);
    int         s;
    logic       p;
    logic [7:0] cc;
    logic [1:0] e;
    s  = 0;
    for (int i = 1; i <= 7; i++) if (c[i-1]) s = s ^ i;
    p  = ^c;
    cc = c;
    if (p && s != 0) cc[s-1] = ~cc[s-1];
    if (s == 0 && !p) e = 2'b00;
    else if (p)       e = 2'b01;
    else              e = 2'b10;
    return {cc[6], cc[5], cc[4], cc[2], e, 3'(s)};
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    int         s;
    c    = 8'h00;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    s    = 0;
    for (int i = 1; i <= 7; i++) if (c[i-1]) s = s ^ i;
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    c[7] = ^c[6:0];
    return c;
  endfunction

  task automatic step(input logic iv, input logic [7:0] code, input logic ordy,
                      input logic clr, output logic acc);
    logic       xfer;
    logic [1:0] xerr;
    @(negedge clk);
    in_valid  = iv;
    in_code   = code;
    out_ready = ordy;
    clr_stat  = clr;
    #1;
    chk("sec_cnt", 32'(sec_cnt), 32'(msec));
    chk("ded_cnt", 32'(ded_cnt), 32'(mded));
    chk("ded_irq", 32'(ded_irq), 32'(mirq));
    chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
    if (stall_prev) chk("hold_valid", 32'(out_valid), 32'd1);
    xfer = 1'b0;
    xerr = 2'b00;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q[0][8:5]));
        chk("out_err",  32'(out_err),  32'(exp_q[0][4:3]));
        chk("out_syn",  32'(out_syn),  32'(exp_q[0][2:0]));
        xfer = ordy;
        xerr = exp_q[0][4:3];
      end
    end
    acc        = iv && in_ready;
    stall_prev = out_valid && !ordy;
    if (clr) begin
      msec = (xfer && xerr == 2'b01) ? 1 : 0;
      mded = (xfer && xerr == 2'b10) ? 1 : 0;
      mirq = xfer && xerr == 2'b10;
    end else if (xfer) begin
      if (xerr == 2'b01 && msec < 65535) msec++;
      if (xerr == 2'b10 && mded < 65535) mded++;
      if (xerr == 2'b10) mirq = 1'b1;
    end
    if (xfer) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_decode(code));
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic       acc;
    logic       saw_low;
    logic [7:0] code;
    logic [7:0] burst [8];
    int         idx;
    int         a;
    int         b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 8'h00;
    out_ready = 1'b0;
    clr_stat  = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_out_syn",   32'(out_syn),   32'd0);
    chk("rst_sec_cnt",   32'(sec_cnt),   32'd0);
    chk("rst_ded_cnt",   32'(ded_cnt),   32'd0);
    chk("rst_ded_irq",   32'(ded_irq),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean word and two-cycle latency.
    step(1'b1, 8'h55, 1'b1, 1'b0, acc);
    chk("accept_55", 32'(acc), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    chk("clean_data", 32'(out_data), 32'hB);
    chk("clean_err",  32'(out_err),  32'd0);
    chk("clean_syn",  32'(out_syn),  32'd0);
    drain();
    chk("clean_cnt", 32'(sec_cnt) + 32'(ded_cnt), 32'd0);

    // Single error, parity-bit error, double error.
    step(1'b1, 8'h45, 1'b1, 1'b0, acc);
    step(1'b1, 8'hD5, 1'b1, 1'b0, acc);
    step(1'b1, 8'h56, 1'b1, 1'b0, acc);
    chk("sec5_data", 32'(out_data), 32'hB);
    chk("sec5_syn",  32'(out_syn),  32'd5);
    chk("sec5_err",  32'(out_err),  32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("p7_data", 32'(out_data), 32'hB);
    chk("p7_err",  32'(out_err),  32'd1);
    chk("p7_syn",  32'(out_syn),  32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("ded_err", 32'(out_err), 32'd2);
    chk("ded_syn", 32'(out_syn), 32'd3);
    drain();
    chk("dir_sec_cnt", 32'(sec_cnt), 32'd2);
    chk("dir_ded_cnt", 32'(ded_cnt), 32'd1);
    chk("dir_ded_irq", 32'(ded_irq), 32'd1);

    // Clear coinciding with a corrected transfer.
    step(1'b1, 8'h45, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b1, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("clr_sec_cnt", 32'(sec_cnt), 32'd1);
    chk("clr_ded_cnt", 32'(ded_cnt), 32'd0);
    chk("clr_ded_irq", 32'(ded_irq), 32'd0);

    // Backpressure burst.
    for (int i = 0; i < 8; i++) burst[i] = encode(4'(i + 3)) ^ ((i % 3 == 0) ? 8'h10 : 8'h00);
    idx     = 0;
    saw_low = 1'b0;
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      step(1'b1, burst[idx], !(cyc >= 3 && cyc <= 5), 1'b0, acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd8);
    chk("bp_in_ready_low", 32'(saw_low), 32'd1);
    drain();

    // Saturation of ded_cnt.
    @(negedge clk);
    force dut.ded_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.ded_cnt_q;
    mded = 65535;
    step(1'b1, 8'h56, 1'b1, 1'b0, acc);
    drain();
    chk("ded_saturate", 32'(ded_cnt), 32'hFFFF);

    // Randomized traffic.
    idx  = 0;
    code = 8'h00;
    for (int cyc = 0; cyc < 3000 && idx < 300; cyc++) begin
      if (!in_valid || acc) begin
        code = encode(4'($urandom_range(0, 15)));
        case ($urandom_range(0, 3))
          1: code[$urandom_range(0, 7)] = ~code[$urandom_range(0, 7)];
          2: begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            code[a] = ~code[a];
            code[b] = ~code[b];
          end
          3: code = 8'($urandom());
          default: ;
        endcase
      end
      step($urandom_range(0, 3) != 0, code, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, acc);
      if (acc) idx++;
    end
    chk("rand_count", 32'(idx), 32'd300);
    drain();

    // Reset with both stages full.
    step(1'b1, 8'h45, 1'b0, 1'b0, acc);
    step(1'b1, 8'h56, 1'b0, 1'b0, acc);
    step(1'b1, 8'h55, 1'b0, 1'b0, acc);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_sec_cnt",   32'(sec_cnt),   32'd0);
    chk("mid_rst_ded_cnt",   32'(ded_cnt),   32'd0);
    chk("mid_rst_ded_irq",   32'(ded_irq),   32'd0);
    exp_q.delete();
    msec       = 0;
    mded       = 0;
    mirq       = 1'b0;
    stall_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  32'(out_data),  32'hB);
    chk("post_rst_err",   32'(out_err),   32'd0);
    drain();
    chk("post_rst_cnt", 32'(sec_cnt) + 32'(ded_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
